ab_pattern_gen: RTL
===================

AB_PATTERN_GEN -- requirements
Module: ab_pattern_gen

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port load_en, input, 1, write enable for the pattern memory.
REQ-004 SHALL have port load_addr, input, 3, pattern memory write address.
REQ-005 SHALL have port load_data, input, 2, pattern entry; bit1 = A, bit0 = B.
REQ-006 SHALL have port len, input, 4, number of steps per pass.
REQ-007 SHALL have port loop, input, 1, repeat the pattern instead of finishing.
REQ-008 SHALL have port start, input, 1, begin a run.
REQ-009 SHALL have port stop, input, 1, abort a run.
REQ-010 SHALL have port y, input, 1, response from the FSM under drive, sampled each step.
REQ-011 SHALL have port A, output, 1, registered stimulus bit A.
REQ-012 SHALL have port B, output, 1, registered stimulus bit B.
REQ-013 SHALL have port busy, output, 1, high while in RUN.
REQ-014 SHALL have port done, output, 1, one-cycle pulse on normal completion.
REQ-015 SHALL have port idx, output, 3, current step index.
REQ-016 SHALL have port y_log, output, 8, captured y per step; bit k = step k.

Function
REQ-017 SHALL hold an 8 x 2-bit pattern memory, written at load_addr with load_data when load_en=1 and state is not RUN; writes during RUN SHALL be ignored.
REQ-018 SHALL implement states IDLE, RUN, DONE.
REQ-019 SHALL use effective length L = 8 for len >= 8, else L = len.
REQ-020 SHALL, in IDLE or DONE, with start=1 and L != 0, enter RUN next edge: idx <= 0, {A,B} <= pat[0], y_log <= 0.
REQ-021 SHALL ignore start when L = 0, or when start=1 in RUN.
REQ-022 SHALL, in RUN, hold each {A,B} for exactly one cycle; each edge SHALL store y into y_log[idx].
REQ-023 SHALL, in RUN with idx < L-1, advance idx <= idx+1 and {A,B} <= pat[idx+1].
REQ-024 SHALL, in RUN with idx = L-1 and loop=1, wrap idx <= 0 and drive {A,B} <= pat[0]; y_log is overwritten per step, not cleared.
REQ-025 SHALL, in RUN with idx = L-1 and loop=0, enter DONE with {A,B} <= 0 and idx held at L-1.
REQ-026 SHALL assert done for exactly the one cycle spent in DONE; DONE SHALL move to IDLE on the next edge unless start restarts the run.
REQ-027 SHALL, on stop=1 in RUN, go to IDLE next edge with {A,B} <= 0, idx <= 0, no done pulse, y_log kept; stop SHALL have priority over step advance and wrap.
REQ-028 SHALL drive busy = 1 exactly when in RUN.
REQ-029 SHALL, when start and stop are both 1 in IDLE, give start priority; stop SHALL have no effect outside RUN.
REQ-030 SHALL give each pattern entry one cycle of latency from {A,B} update to y sampling; the stimulus-to-response delay is the consumer's concern.

Reset
REQ-031 SHALL, on rst=1, immediately and asynchronously force state IDLE, A=0, B=0, busy=0, done=0, idx=0, y_log=0, and clear every pattern entry to 2'b00.
REQ-032 SHALL, when rst is asserted mid-RUN, abort the run with no done pulse; after release the block SHALL wait for a new start.

Verification
REQ-033 SHALL be verified for load: pat = {00,10,01,11}, len=4, loop=0, start pulse -> {A,B} = 00,10,01,11 on four consecutive cycles, busy high 4 cycles, done one pulse, then A=B=0.
REQ-034 SHALL be verified for y capture: same run with y = 1,0,1,1 per step -> y_log = 8'b0000_1101.
REQ-035 SHALL be verified for loop: len=2, pat = {10,01}, loop=1 -> A,B sequence 10,01,10,01... with busy held high; stop pulse -> IDLE next edge, A=B=0, no done.
REQ-036 SHALL be verified for boundaries: len=0 start -> stays IDLE; len=12 -> 8 steps; load_en during RUN -> memory unchanged.
REQ-037 SHALL be verified for async reset: rst pulse mid-run, off the clock edge -> outputs zero before the next edge, memory cleared, no done pulse.

Source files
------------

// File: rtl/ab_pattern_gen.sv
// Two-bit stimulus sequencer: replays an 8-entry {A,B} pattern memory one step
// per cycle, optionally looping, and captures the FSM-under-drive response y.
module ab_pattern_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  logic [2:0] load_addr,
  input  logic [1:0] load_data,
  input  logic [3:0] len,
  input  logic       loop,
  input  logic       start,
  input  logic       stop,
  input  logic       y,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic [2:0] idx,
  output logic [7:0] y_log
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ab_q,    ab_d;
  logic [2:0] idx_q,   idx_d;
  logic [7:0] ylog_q,  ylog_d;
  logic [1:0] pat_q [8];

  logic       len_zero;
  logic [2:0] last_idx;
  logic       at_last;
  logic       pat_we;

  // Any len of 8 or more plays the full memory.
  assign len_zero = (len == 4'd0);
  assign last_idx = len[3] ? 3'd7 : (len[2:0] - 3'd1);
  assign at_last  = (idx_q >= last_idx);
  assign pat_we   = load_en && (state_q != S_RUN);

  // NOTE: the pattern memory is reset like ordinary registers because reset
  // must leave every entry at 2'b00; this keeps it out of RAM macros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) pat_q[i] <= 2'b00;
    end else if (pat_we) begin
      pat_q[load_addr] <= load_data;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ab_d    = ab_q;
    idx_d   = idx_q;
    ylog_d  = ylog_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !len_zero) begin
          state_d = S_RUN;
          idx_d   = 3'd0;
          ab_d    = pat_q[0];
          ylog_d  = 8'h00;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          ab_d    = 2'b00;
          idx_d   = 3'd0;
        end else begin
          ylog_d[idx_q] = y;
          if (!at_last) begin
            idx_d = idx_q + 3'd1;
            ab_d  = pat_q[idx_q + 3'd1];
          end else if (loop) begin
            idx_d = 3'd0;
            ab_d  = pat_q[0];
          end else begin
            state_d = S_DONE;
            ab_d    = 2'b00;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        ab_d    = 2'b00;
        idx_d   = 3'd0;
      end
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ab_q    <= 2'b00;
      idx_q   <= 3'd0;
      ylog_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ab_q    <= ab_d;
      idx_q   <= idx_d;
      ylog_q  <= ylog_d;
    end
  end

  assign A     = ab_q[1];
  assign B     = ab_q[0];
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign idx   = idx_q;
  assign y_log = ylog_q;

endmodule
